pc_redirect_ctrl: RTL and testbench

Parametrised PC-redirect controller for the pipelined core. It arbitrates up to NUM_SRC redirect requests raised by pipeline stages, where index 0 is the oldest stage and has the highest priority. It registers the winning target and source index for the PC mux and issues a one-cycle flush. A squash window then masks requests from younger, wrong-path stages until the flush has drained. A saturating redirect counter is provided for performance monitoring.

---
 rtl/pc_redirect_ctrl.sv | 86 ++++++++
 tb/tb_pc_redirect_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: priority redirect arbiter with registered PC select, flush pulse and squash window
//   clk, reset        : clock, synchronous active-high reset
//   req_valid         : per-source redirect request (index 0 oldest, highest priority)
//   req_target        : per-source target, source i at [i*PC_W +: PC_W]
//   stall             : freezes the squash countdown only
//   pc_sel_valid/flush: one-cycle pulse after an accepted redirect
//   pc_sel_idx/pc_next: registered winner index and target
//   squash_active     : masking window open
//   redirect_cnt      : saturating count of accepted redirects
module pc_redirect_ctrl #(
    parameter int NUM_SRC    = 7,
    parameter int PC_W       = 16,
    parameter int SQUASH_CYC = 3,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      req_valid,
    input  logic [NUM_SRC*PC_W-1:0] req_target,
    input  logic                    stall,
    output logic                    pc_sel_valid,
    output logic [IDX_W-1:0]        pc_sel_idx,
    output logic [PC_W-1:0]         pc_next,
    output logic                    flush,
    output logic                    squash_active,
    output logic [CNT_W-1:0]        redirect_cnt
);
    localparam int SQ_W = (SQUASH_CYC > 0) ? $clog2(SQUASH_CYC + 1) : 1;

    logic [SQ_W-1:0]  sq_cnt_q, sq_cnt_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             pc_sel_valid_q, pc_sel_valid_d;
    logic [IDX_W-1:0] pc_sel_idx_q, pc_sel_idx_d;
    logic [PC_W-1:0]  pc_next_q, pc_next_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic             accept;
    logic [IDX_W-1:0] win_idx;
    logic [PC_W-1:0]  win_tgt;

    always_comb begin
        accept  = 1'b0;
        win_idx = '0;
        win_tgt = '0;
        // descending scan so the lowest eligible index is the final assignment
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_valid[i] && (sq_cnt_q == '0 || i < int'(lock_idx_q))) begin
                accept  = 1'b1;
                win_idx = IDX_W'(i);
                win_tgt = req_target[i*PC_W +: PC_W];
            end
        end
        pc_sel_valid_d = accept;
        pc_sel_idx_d   = accept ? win_idx : pc_sel_idx_q;
        pc_next_d      = accept ? win_tgt : pc_next_q;
        lock_idx_d     = accept ? win_idx : lock_idx_q;
        sq_cnt_d       = accept ? SQ_W'(SQUASH_CYC) :
                         (sq_cnt_q != '0 && !stall) ? sq_cnt_q - SQ_W'(1) : sq_cnt_q;
        redirect_cnt_d = (accept && !(&redirect_cnt_q)) ? redirect_cnt_q + CNT_W'(1) : redirect_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sq_cnt_q       <= '0;
            lock_idx_q     <= '0;
            pc_sel_valid_q <= 1'b0;
            pc_sel_idx_q   <= '0;
            pc_next_q      <= '0;
            redirect_cnt_q <= '0;
        end else begin
            sq_cnt_q       <= sq_cnt_d;
            lock_idx_q     <= lock_idx_d;
            pc_sel_valid_q <= pc_sel_valid_d;
            pc_sel_idx_q   <= pc_sel_idx_d;
            pc_next_q      <= pc_next_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign pc_sel_valid  = pc_sel_valid_q;
    assign flush         = pc_sel_valid_q;
    assign pc_sel_idx    = pc_sel_idx_q;
    assign pc_next       = pc_next_q;
    assign squash_active = (sq_cnt_q != '0);
    assign redirect_cnt  = redirect_cnt_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: scoreboard bench for two pc_redirect_ctrl configurations against a reference model
module tb_pc_redirect_ctrl;
    localparam int N = 7;
    localparam int W = 16;

    typedef struct {
        logic        v;
        int          idx;
        logic [15:0] tgt;
        int          cnt;
        logic        sq;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_target = '0;
    logic           stall = 1'b0;
    logic           v0, f0, s0, v1, f1, s1;
    logic [2:0]     i0, i1;
    logic [15:0]    p0, p1, c0;
    logic [1:0]     c1;

    logic [15:0] tg [N];
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          checks = 0;
    int          failures = 0;

    // reference state per configuration: [0] defaults, [1] SQUASH_CYC=0 / CNT_W=2
    int          win_left [2];
    int          lock [2];
    int          cnt [2];
    logic        mv [2];
    int          midx [2];
    logic [15:0] mtgt [2];
    int          sq_len [2];
    int          cnt_max [2];

    always #5 clk = ~clk;

    pc_redirect_ctrl dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target), .stall(stall),
        .pc_sel_valid(v0), .pc_sel_idx(i0), .pc_next(p0), .flush(f0), .squash_active(s0), .redirect_cnt(c0)
    );

    pc_redirect_ctrl #(.SQUASH_CYC(0), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target), .stall(stall),
        .pc_sel_valid(v1), .pc_sel_idx(i1), .pc_next(p1), .flush(f1), .squash_active(s1), .redirect_cnt(c1)
    );

    task automatic model(input int k, input logic r, input logic [N-1:0] rv, input logic st);
        int w;
        w = -1;
        if (r) begin
            win_left[k] = 0; lock[k] = 0; cnt[k] = 0; mv[k] = 0; midx[k] = 0; mtgt[k] = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (w < 0 && rv[i] && (win_left[k] == 0 || i < lock[k])) w = i;
            mv[k] = (w >= 0);
            if (w >= 0) begin
                midx[k] = w; mtgt[k] = tg[w]; lock[k] = w; win_left[k] = sq_len[k];
                cnt[k] = (cnt[k] < cnt_max[k]) ? cnt[k] + 1 : cnt[k];
            end else if (win_left[k] > 0 && !st) begin
                win_left[k] = win_left[k] - 1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] rv, input logic st);
        exp_t e;
        @(negedge clk);
        reset = r; req_valid = rv; stall = st;
        for (int i = 0; i < N; i++) req_target[i*W +: W] = tg[i];
        for (int k = 0; k < 2; k++) begin
            model(k, r, rv, st);
            e.v = mv[k]; e.idx = midx[k]; e.tgt = mtgt[k]; e.cnt = cnt[k]; e.sq = (win_left[k] > 0);
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic rand_tg();
        for (int i = 0; i < N; i++) tg[i] = 16'($urandom);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("d0_valid", int'(v0), int'(e.v));
                chk("d0_flush", int'(f0), int'(e.v));
                chk("d0_idx", int'(i0), e.idx);
                chk("d0_pc_next", int'(p0), int'(e.tgt));
                chk("d0_squash", int'(s0), int'(e.sq));
                chk("d0_cnt", int'(c0), e.cnt);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("d1_valid", int'(v1), int'(e.v));
                chk("d1_flush", int'(f1), int'(e.v));
                chk("d1_idx", int'(i1), e.idx);
                chk("d1_pc_next", int'(p1), int'(e.tgt));
                chk("d1_squash", int'(s1), int'(e.sq));
                chk("d1_cnt", int'(c1), e.cnt);
            end
        end
    end

    initial begin
        sq_len[0] = 3; cnt_max[0] = 65535;
        sq_len[1] = 0; cnt_max[1] = 3;
        for (int k = 0; k < 2; k++) begin
            win_left[k] = 0; lock[k] = 0; cnt[k] = 0; mv[k] = 0; midx[k] = 0; mtgt[k] = 0;
        end
        for (int i = 0; i < N; i++) tg[i] = 16'(i * 16'h0111);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        tg[2] = 16'h0040; tg[5] = 16'h0123;
        cyc(0, 7'b0100100, 0);
        repeat (4) cyc(0, 0, 0);
        cyc(0, 7'b0000100, 0);
        repeat (4) cyc(0, 7'b0010000, 0);
        repeat (4) cyc(0, 0, 0);
        cyc(0, 7'b0001000, 0);
        tg[0] = 16'h0FFF;
        cyc(0, 7'b0000001, 0);
        repeat (4) cyc(0, 0, 0);
        cyc(0, 7'b0000010, 0);
        cyc(0, 7'b1000000, 1);
        cyc(0, 7'b1000000, 1);
        repeat (4) cyc(0, 7'b1000000, 0);
        repeat (5) cyc(0, 7'b1000000, 0);
        cyc(0, 7'b0000100, 0);
        cyc(1, 7'b0100000, 0);
        cyc(0, 7'b0100000, 0);
        repeat (3) cyc(0, 0, 0);
        repeat (2000) begin
            rand_tg();
            cyc(($urandom_range(0, 99) < 2), N'($urandom & $urandom & $urandom), ($urandom_range(0, 3) == 0));
        end
        cyc(0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("q_drained", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
